// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one single-port memory between the
// instruction-fetch (IF) and load/store (LS) ports, one transaction in flight.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_if_req/addr              fetch request (always a read)
//   o_if_gnt/rvalid/rdata      fetch grant pulse, data pulse, held data
//   i_ls_req/addr/we/mask/wdata load/store request
//   o_ls_gnt/rvalid/rdata      ls grant pulse, done pulse, held load data
//   o_mem_req/addr/we/mask/wdata  memory request, held until i_mem_ready
//   i_mem_ready/rvalid/rdata   memory accept and read response
module mem_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic                i_ls_we,
  input  logic [DATA_W/8-1:0] i_ls_mask,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_mask,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int MW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // last winner / current owner: 1 = LS, 0 = IF
  logic last_ls_q, last_ls_d;
  logic own_ls_q, own_ls_d;

  logic              if_gnt_q, if_gnt_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              if_rv_q, if_rv_d;
  logic              ls_rv_q, ls_rv_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [MW-1:0]     mem_mask_q, mem_mask_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic any_req;
  logic win_ls;
  logic win_if;

  assign any_req = i_if_req | i_ls_req;
  // on a tie the port that did not win last time goes
  assign win_ls  = i_ls_req & (~i_if_req | ~last_ls_q);
  assign win_if  = i_if_req & ~win_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        if (i_mem_ready) state_d = mem_we_q ? IDLE : RESP;
      end
      RESP: begin
        if (i_mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_ls_d   = last_ls_q;
    own_ls_d    = own_ls_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rv_d     = 1'b0;
    ls_rv_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_mask_d  = mem_mask_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          if_gnt_d    = win_if;
          ls_gnt_d    = win_ls;
          last_ls_d   = win_ls;
          own_ls_d    = win_ls;
          mem_req_d   = 1'b1;
          mem_addr_d  = win_ls ? i_ls_addr : i_if_addr;
          mem_we_d    = win_ls & i_ls_we;
          mem_mask_d  = (win_ls & i_ls_we) ? i_ls_mask : '1;
          mem_wdata_d = win_ls ? i_ls_wdata : '0;
        end
      end
      ISSUE: begin
        if (!i_mem_ready) begin
          mem_req_d = 1'b1;
        end else if (mem_we_q) begin
          // only LS can write, so the store completes on LS
          ls_rv_d    = 1'b1;
          ls_rdata_d = '0;
        end
      end
      RESP: begin
        if (i_mem_rvalid) begin
          if (own_ls_q) begin
            ls_rv_d    = 1'b1;
            ls_rdata_d = i_mem_rdata;
          end else begin
            if_rv_d    = 1'b1;
            if_rdata_d = i_mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls_q   <= 1'b0;
      own_ls_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rv_q     <= 1'b0;
      ls_rv_q     <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      last_ls_q   <= last_ls_d;
      own_ls_q    <= own_ls_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rv_q     <= if_rv_d;
      ls_rv_q     <= ls_rv_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_mask_q  <= mem_mask_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_if_gnt    = if_gnt_q;
  assign o_ls_gnt    = ls_gnt_q;
  assign o_if_rvalid = if_rv_q;
  assign o_ls_rvalid = ls_rv_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_mask  = mem_mask_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule
